mem_phase_seq: RTL

//  Initiator for the time-multiplexed instruction/data BRAM. Generates the one-hot

---
 rtl/mem_phase_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_phase_seq.sv
// ============================================================================
// mem_phase_seq
// ----------------------------------------------------------------------------
// Initiator for the time-multiplexed instruction/data BRAM. A 4-cycle frame
// rotates a one-hot strobe through the BRAM ports:
//
//   P0: i1re  (instruction port 1 read)
//   P1: i2re  (instruction port 2 read)
//   P2: dre   (data read, plus the single data write when requested)
//   P3: gwe   (global write/turnaround slot)
//
// The core gets one request/response pair per frame. A request is taken on
// the edge that leaves IDLE or P3. Its fields are registered and held for the
// whole frame. The BRAM read data is captured one cycle after each strobe.
//
// Handshake: req_ready is high in IDLE/P3 while en is high. A request is
// consumed on any rising edge where req_valid && req_ready. rsp_valid is a
// single-cycle pulse with no back-pressure. rsp_i1/rsp_i2/rsp_d hold their
// values until the next accepted frame overwrites them.
//
// Ports
//   idclk, rst_n                      clock, asynchronous active-low reset
//   en                                run enable, sampled at frame boundary
//   req_valid / req_ready             request handshake
//   req_pc1, req_pc2                  instruction addresses
//   req_draddr, req_dwaddr            data read / write addresses
//   req_wdata, req_we                 data write value / write request
//   i1re, i2re, dre, gwe              one-hot phase strobes to BRAM
//   i1addr, i2addr, draddr, dwaddr    BRAM addresses (frame-stable)
//   din, dwe                          BRAM write data / write enable
//   i1out, i2out, dout                BRAM read data
//   rsp_valid, rsp_i1, rsp_i2, rsp_d  response pulse and captured words
//   dbg_state                         current FSM state (IDLE=0, P0..P3=1..4)
// ============================================================================
module mem_phase_seq #(
    parameter int WORD_SIZE = 16,
    parameter int IADDR_W   = 16,
    parameter int DADDR_W   = 3
) (
    input  logic                 idclk,
    input  logic                 rst_n,
    input  logic                 en,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IADDR_W-1:0]   req_pc1,
    input  logic [IADDR_W-1:0]   req_pc2,
    input  logic [DADDR_W-1:0]   req_draddr,
    input  logic [DADDR_W-1:0]   req_dwaddr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic                 req_we,

    output logic                 i1re,
    output logic                 i2re,
    output logic                 dre,
    output logic                 gwe,
    output logic [IADDR_W-1:0]   i1addr,
    output logic [IADDR_W-1:0]   i2addr,
    output logic [DADDR_W-1:0]   draddr,
    output logic [DADDR_W-1:0]   dwaddr,
    output logic [WORD_SIZE-1:0] din,
    output logic                 dwe,
    input  logic [15:0]          i1out,
    input  logic [15:0]          i2out,
    input  logic [WORD_SIZE-1:0] dout,

    output logic                 rsp_valid,
    output logic [15:0]          rsp_i1,
    output logic [15:0]          rsp_i2,
    output logic [WORD_SIZE-1:0] rsp_d,

    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Set for the frame that carries an accepted request. It gates the
    // captures and the response pulse.
    logic   frame_act;
    // Write request that was latched with the current frame.
    logic   wr_flag;

    logic   boundary;
    logic   accept;

    assign dbg_state = state;

    // A frame boundary is the edge that leaves IDLE or P3. en is only looked
    // at here, so dropping it mid-frame lets the frame finish.
    assign boundary  = (state == S_IDLE) || (state == S_P3);

    // rst_n is included so that ready stays low while reset is held, even
    // when en is already high.
    assign req_ready = boundary && en && rst_n;
    assign accept    = req_ready && req_valid;

    // The write shares the dre edge with the data read. A same-address read
    // in the same frame therefore returns the old contents.
    assign dwe       = wr_flag && (state == S_P2);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge idclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and phase strobes
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        i1re      = 1'b0;
        i2re      = 1'b0;
        dre       = 1'b0;
        gwe       = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_P0;
                end
            end
            S_P0: begin
                i1re      = 1'b1;
                state_nxt = S_P1;
            end
            S_P1: begin
                i2re      = 1'b1;
                state_nxt = S_P2;
            end
            S_P2: begin
                dre       = 1'b1;
                state_nxt = S_P3;
            end
            S_P3: begin
                gwe       = 1'b1;
                state_nxt = en ? S_P0 : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch. Addresses keep their old values through frames that have
    // no request. The write flag and the frame-active flag are refreshed at
    // every boundary, so an empty frame never writes or responds.
    // ------------------------------------------------------------------------
    always_ff @(posedge idclk or negedge rst_n) begin
        if (!rst_n) begin
            i1addr    <= '0;
            i2addr    <= '0;
            draddr    <= '0;
            dwaddr    <= '0;
            din       <= '0;
            wr_flag   <= 1'b0;
            frame_act <= 1'b0;
        end else if (boundary) begin
            wr_flag   <= accept && req_we;
            frame_act <= accept;
            if (accept) begin
                i1addr <= req_pc1;
                i2addr <= req_pc2;
                draddr <= req_draddr;
                dwaddr <= req_dwaddr;
                din    <= req_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response capture. The BRAM returns data one cycle after each strobe, so
    // each word is taken at the end of the phase that follows its strobe.
    // The response pulse covers the cycle after P3.
    // ------------------------------------------------------------------------
    always_ff @(posedge idclk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_i1    <= '0;
            rsp_i2    <= '0;
            rsp_d     <= '0;
        end else begin
            rsp_valid <= (state == S_P3) && frame_act;
            if (frame_act) begin
                if (state == S_P1) begin
                    rsp_i1 <= i1out;
                end
                if (state == S_P2) begin
                    rsp_i2 <= i2out;
                end
                if (state == S_P3) begin
                    rsp_d <= dout;
                end
            end
        end
    end

endmodule
